// File: rtl/div_request_sequencer.sv
// div_request_sequencer
//
// Front-end for binary_divider. Requests ({dividend, divisor, tag}) enter a
// two-entry FIFO. One request at a time is launched into the divider with a
// single-cycle div_en pulse. The quotient is captured on div_done, and the
// result is presented with its tag on a valid/ready output.
// A zero divisor is answered directly without launching the divider.
// A quotient that needs more than 32 bits is flagged in out_err[1].
//
// Optional feature: define DIV_TIMEOUT_EN to abort a launch that waits more
// than TIMEOUT_CYCLES cycles for div_done. The aborted request reports
// out_err = 3'b100 and out_quotient = 0. Without the macro, the sequencer
// waits for div_done indefinitely and out_err[2] is always 0.
//
// Ports
//   clk, reset            clock; synchronous active-high reset
//   in_valid/in_ready     request handshake; in_ready = FIFO not full
//   in_dividend[63:0]     request dividend
//   in_divisor[63:0]      request divisor
//   in_tag[TAG_W-1:0]     request tag
//   div_en                1-cycle divider start pulse
//   g_dividend_Q[63:0]    operand to the divider, stable from div_en to div_done
//   g_divider_Q[63:0]     operand to the divider, stable from div_en to div_done
//   div_quotient[31:0]    divider result, valid while div_done is high
//   div_done              divider completion pulse
//   out_valid/out_ready   result handshake; out_valid is held until out_ready
//   out_quotient[31:0]    result quotient
//   out_tag               result tag
//   out_err[2:0]          {timeout, overflow, divide-by-zero}
//
// State  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for a FIFO entry; pop it and screen for a zero divisor
// LAUNCH | div_en high for this single cycle
// WAIT   | divider busy; wait for div_done (or a timeout when enabled)
// HOLD   | result presented with out_valid=1 until out_ready

module div_request_sequencer #(
  parameter int TAG_W          = 4,
  parameter int TIMEOUT_CYCLES = 128
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [63:0]      in_dividend,
  input  logic [63:0]      in_divisor,
  input  logic [TAG_W-1:0] in_tag,
  output logic             div_en,
  output logic [63:0]      g_dividend_Q,
  output logic [63:0]      g_divider_Q,
  input  logic [31:0]      div_quotient,
  input  logic             div_done,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_quotient,
  output logic [TAG_W-1:0] out_tag,
  output logic [2:0]       out_err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    HOLD   = 2'd3
  } state_t;

  state_t state_q, state_d;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  // ------------------------------------------------------------------
  // Two-entry request FIFO
  // ------------------------------------------------------------------
  logic [63:0]      fifo_dvd [2];
  logic [63:0]      fifo_dvs [2];
  logic [TAG_W-1:0] fifo_tag [2];
  logic             wr_ptr, rd_ptr;
  logic [1:0]       count;
  logic             push, pop;
  logic [63:0]      head_dvd, head_dvs;
  logic [TAG_W-1:0] head_tag;
  logic             head_zero;

  assign in_ready  = (count != 2'd2);
  assign push      = in_valid && in_ready;
  assign pop       = (state_q == IDLE) && (count != 2'd0);
  assign head_dvd  = fifo_dvd[rd_ptr];
  assign head_dvs  = fifo_dvs[rd_ptr];
  assign head_tag  = fifo_tag[rd_ptr];
  assign head_zero = (head_dvs == 64'd0);

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        fifo_dvd[wr_ptr] <= in_dividend;
        fifo_dvs[wr_ptr] <= in_divisor;
        fifo_tag[wr_ptr] <= in_tag;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // ------------------------------------------------------------------
  // Optional launch timeout: a down-counter loaded in LAUNCH.
  // It expires after TIMEOUT_CYCLES cycles in WAIT.
  // ------------------------------------------------------------------
  logic tmo_hit;

`ifdef DIV_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      tmo_cnt <= '0;
    end else if (state_q == LAUNCH) begin
      tmo_cnt <= TMO_W'(TIMEOUT_CYCLES - 1);
    end else if ((state_q == WAIT) && (tmo_cnt != '0)) begin
      tmo_cnt <= tmo_cnt - 1'b1;
    end
  end

  // div_done in the same cycle as expiry takes priority.
  assign tmo_hit = (state_q == WAIT) && !div_done && (tmo_cnt == '0);
`else
  assign tmo_hit = 1'b0;
`endif

  // ------------------------------------------------------------------
  // FSM
  // ------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    div_en  = 1'b0;
    case (state_q)
      IDLE: begin
        if (count != 2'd0) begin
          state_d = head_zero ? HOLD : LAUNCH;
        end
      end
      LAUNCH: begin
        div_en  = 1'b1;
        state_d = WAIT;
      end
      WAIT: begin
        if (div_done || tmo_hit) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // HOLD is exactly the interval in which a result is presented.
  assign out_valid = (state_q == HOLD);

  // ------------------------------------------------------------------
  // Operand and result registers
  // ------------------------------------------------------------------
  // The quotient fits in 32 bits only if the divisor exceeds dividend[63:32].
  // When divisor[63:32] is non-zero, this always holds.
  logic overflow;
  assign overflow = (g_divider_Q[63:32] == 32'd0) &&
                    (g_dividend_Q[63:32] >= g_divider_Q[31:0]);

  always_ff @(posedge clk) begin
    if (reset) begin
      g_dividend_Q <= '0;
      g_divider_Q  <= '0;
      out_quotient <= '0;
      out_tag      <= '0;
      out_err      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pop) begin
            out_tag <= head_tag;
            if (head_zero) begin
              out_quotient <= 32'hFFFF_FFFF;
              out_err      <= 3'b001;
            end else begin
              g_dividend_Q <= head_dvd;
              g_divider_Q  <= head_dvs;
            end
          end
        end
        WAIT: begin
          if (div_done) begin
            out_quotient <= div_quotient;
            out_err      <= {1'b0, overflow, 1'b0};
          end else if (tmo_hit) begin
            out_quotient <= 32'd0;
            out_err      <= 3'b100;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_request_sequencer.sv
`timescale 1ns/1ps

module tb_div_request_sequencer;

  localparam int TAG_W = 4;
`ifdef DIV_TIMEOUT_EN
  localparam int TMO = 16;
`else
  localparam int TMO = 128;
`endif

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [63:0]      in_dividend = '0;
  logic [63:0]      in_divisor = '0;
  logic [TAG_W-1:0] in_tag = '0;
  logic             div_en;
  logic [63:0]      g_dividend_Q, g_divider_Q;
  logic [31:0]      div_quotient;
  logic             div_done;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [31:0]      out_quotient;
  logic [TAG_W-1:0] out_tag;
  logic [2:0]       out_err;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  div_request_sequencer #(.TAG_W(TAG_W), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_dividend(in_dividend), .in_divisor(in_divisor), .in_tag(in_tag),
    .div_en(div_en), .g_dividend_Q(g_dividend_Q), .g_divider_Q(g_divider_Q),
    .div_quotient(div_quotient), .div_done(div_done),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_quotient(out_quotient), .out_tag(out_tag), .out_err(out_err)
  );

  // Divider stand-in: div_done goes high 67 cycles after the div_en cycle.
  int   dcnt = -1;
  int   en_cnt = 0;
  logic done_mute = 1'b0;
  logic stray = 1'b0;

  always @(negedge clk) begin
    if (reset) begin
      dcnt = -1;
    end else if (div_en) begin
      dcnt = 67;
      en_cnt++;
    end else if (dcnt >= 0) begin
      dcnt--;
    end
  end

  assign div_done     = ((dcnt == 0) && !done_mute) || stray;
  assign div_quotient = (g_divider_Q != 64'd0) ? 32'(g_dividend_Q / g_divider_Q) : 32'd0;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", name, obs, exp);
    end
  endtask

  task automatic send(input logic [63:0] dvd, input logic [63:0] dvs, input logic [TAG_W-1:0] tag);
    int n;
    n = 0;
    @(negedge clk);
    in_valid    = 1'b1;
    in_dividend = dvd;
    in_divisor  = dvs;
    in_tag      = tag;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Counts negedges from the accepting edge until out_valid is seen.
  task automatic wait_valid(input string name, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 400);
    chk(name, {63'd0, out_valid}, 64'd1);
  endtask

  task automatic take(input string name, input logic [31:0] q, input logic [TAG_W-1:0] tag,
                      input logic [2:0] err);
    int n;
    wait_valid({name, "_valid"}, n);
    chk({name, "_quot"}, {32'd0, out_quotient}, {32'd0, q});
    chk({name, "_tag"}, {60'd0, out_tag}, {60'd0, tag});
    chk({name, "_err"}, {61'd0, out_err}, {61'd0, err});
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({name, "_drop"}, {63'd0, out_valid}, 64'd0);
  endtask

  initial begin
    int n;
    int en0;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_div_en", {63'd0, div_en}, 64'd0);
    chk("rst_g_dvd", g_dividend_Q, 64'd0);
    chk("rst_quot", {32'd0, out_quotient}, 64'd0);
    chk("rst_err", {61'd0, out_err}, 64'd0);
    reset = 1'b0;

    // 100/7: latency 70, single div_en pulse
    out_ready = 1'b1;
    en0 = en_cnt;
    send(64'd100, 64'd7, 4'd3);
    wait_valid("t1_valid", n);
    chk("t1_latency", 64'(n), 64'd70);
    chk("t1_quot", {32'd0, out_quotient}, 64'd14);
    chk("t1_tag", {60'd0, out_tag}, 64'd3);
    chk("t1_err", {61'd0, out_err}, 64'd0);
    chk("t1_en_pulses", 64'(en_cnt - en0), 64'd1);
    @(posedge clk);
    #1;
    chk("t1_drop", {63'd0, out_valid}, 64'd0);
    out_ready = 1'b0;

    // Divide by zero: no launch, valid 2 cycles after acceptance
    en0 = en_cnt;
    send(64'd55, 64'd0, 4'd4);
    wait_valid("dz_valid", n);
    chk("dz_latency", 64'(n), 64'd2);
    chk("dz_quot", {32'd0, out_quotient}, 64'hFFFF_FFFF);
    chk("dz_err", {61'd0, out_err}, 64'd1);
    chk("dz_tag", {60'd0, out_tag}, 64'd4);
    chk("dz_no_en", 64'(en_cnt - en0), 64'd0);
    take("dz", 32'hFFFF_FFFF, 4'd4, 3'b001);

    // Quotient overflow; result held while out_ready stays low
    en0 = en_cnt;
    send(64'h1_0000_0000, 64'd1, 4'hA);
    wait_valid("ov_valid", n);
    repeat (3) @(negedge clk);
    chk("ov_held", {63'd0, out_valid}, 64'd1);
    chk("ov_err", {61'd0, out_err}, 64'd2);
    take("ov", 32'd0, 4'hA, 3'b010);
    chk("ov_en_pulses", 64'(en_cnt - en0), 64'd1);

    // Three back-to-back requests with out_ready low
    send(64'd1000, 64'd10, 4'd5);
    send(64'd77, 64'd0, 4'd6);
    send(64'h5_0000_0000, 64'h1_0000_0000, 4'd9);
    chk("bp_full", {63'd0, in_ready}, 64'd0);
    take("bp_a", 32'd100, 4'd5, 3'b000);
    take("bp_b", 32'hFFFF_FFFF, 4'd6, 3'b001);
    take("bp_c", 32'd5, 4'd9, 3'b000);
    chk("bp_ready", {63'd0, in_ready}, 64'd1);

    // Reset while in WAIT with a second request buffered
    send(64'd50, 64'd5, 4'd2);
    send(64'd60, 64'd6, 4'd3);
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("mr_out_valid", {63'd0, out_valid}, 64'd0);
    chk("mr_in_ready", {63'd0, in_ready}, 64'd1);
    chk("mr_div_en", {63'd0, div_en}, 64'd0);
    chk("mr_g_dvs", g_divider_Q, 64'd0);
    chk("mr_tag", {60'd0, out_tag}, 64'd0);
    chk("mr_err", {61'd0, out_err}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    en0 = en_cnt;
    repeat (100) @(negedge clk);
    chk("mr_fifo_empty", 64'(en_cnt - en0), 64'd0);
    chk("mr_no_result", {63'd0, out_valid}, 64'd0);

    // Stray div_done while idle is ignored
    @(negedge clk);
    stray = 1'b1;
    @(negedge clk);
    stray = 1'b0;
    repeat (2) @(negedge clk);
    chk("stray_idle", {63'd0, out_valid}, 64'd0);

    send(64'd81, 64'd9, 4'd1);
    take("post", 32'd9, 4'd1, 3'b000);

`ifdef DIV_TIMEOUT_EN
    // Divider never answers: timeout after TMO cycles in WAIT
    done_mute = 1'b1;
    send(64'd10, 64'd2, 4'd7);
    wait_valid("to_valid", n);
    chk("to_latency", 64'(n), 64'(TMO + 3));
    take("to", 32'd0, 4'd7, 3'b100);
    done_mute = 1'b0;
    repeat (80) @(negedge clk);
    chk("to_late_done", {63'd0, out_valid}, 64'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
